// File: rtl/ram4k_arbiter.sv
// ram4k_arbiter: arbitrates two requesters (A = CPU data port, B = DMA/refresh port)
// onto one single-port 4096x16 RAM. The block has three stages:
// accept -> registered RAM drive -> read response.
// Read data is returned to the requester that issued it, at accept + 2 cycles.
// Build option: define RAM4K_ARB_ROUND_ROBIN_EN for a round-robin tie-break.
// When it is undefined (the default), A has fixed priority.
module ram4k_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t a_cmd, b_cmd, sel_cmd;
  logic a_gnt_w, b_gnt_w, accept;
  src_e sel_src;

  assign a_cmd = {a_we, a_addr, a_wdata};
  assign b_cmd = {b_we, b_addr, b_wdata};

`ifdef RAM4K_ARB_ROUND_ROBIN_EN
  src_e last_q, last_d;

  // Grant: a lone requester always wins; on a tie, the one not granted last wins.
  always_comb begin
    a_gnt_w = 1'b0;
    b_gnt_w = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        a_gnt_w = (last_q == SRC_B);
        b_gnt_w = (last_q == SRC_A);
      end else begin
        a_gnt_w = a_req;
        b_gnt_w = b_req;
      end
    end
  end

  // Track the most recent grant for the next tie.
  always_comb begin
    last_d = last_q;
    if (a_gnt_w)      last_d = SRC_A;
    else if (b_gnt_w) last_d = SRC_B;
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= SRC_B;
    else       last_q <= last_d;
  end
`else
  // Grant: fixed priority; B wins only when A is not asking.
  always_comb begin
    a_gnt_w = a_req & ~reset;
    b_gnt_w = b_req & ~a_req & ~reset;
  end
`endif

  assign a_gnt   = a_gnt_w;
  assign b_gnt   = b_gnt_w;
  assign accept  = a_gnt_w | b_gnt_w;
  assign sel_src = a_gnt_w ? SRC_A : SRC_B;
  assign sel_cmd = a_gnt_w ? a_cmd : b_cmd;

  // vld_pipe[1]: a command is driving the RAM this cycle.
  // vld_pipe[2]: a read response is valid this cycle.
  logic [2:1]        vld_pipe_q, vld_pipe_d;
  src_e              src1_q, src1_d, src2_q, src2_d;
  logic              ram_load_q, ram_load_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;

  // Next-state logic. Address and data hold when nothing is accepted.
  // Only reads advance to the response stage.
  always_comb begin
    vld_pipe_d    = {vld_pipe_q[1] & ~ram_load_q, accept};
    src1_d        = accept ? sel_src : src1_q;
    src2_d        = src1_q;
    ram_load_d    = accept & sel_cmd.we;
    ram_address_d = accept ? sel_cmd.addr  : ram_address_q;
    ram_in_d      = accept ? sel_cmd.wdata : ram_in_q;
  end

  // Pipeline registers. Async reset drops in-flight work, including a pending RAM write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q    <= '0;
      src1_q        <= SRC_A;
      src2_q        <= SRC_A;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      ram_load_q    <= ram_load_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
    end
  end

  assign ram_load    = ram_load_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;

  assign a_rvalid = vld_pipe_q[2] & (src2_q == SRC_A);
  assign b_rvalid = vld_pipe_q[2] & (src2_q == SRC_B);
  assign a_rdata  = ram_out;
  assign b_rdata  = ram_out;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Bench for ram4k_arbiter. It includes a behavioural 4096x16 RAM with a registered
// output; a read during a write returns the old word.
// The table holds the per-cycle vectors. Expected RAM writes and read responses are
// recorded per cycle when stimulus is driven, then checked as the DUT produces them.
module tb_ram4k_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
  logic [11:0] ram_address;
  logic        ram_load;

  always #5 clk = ~clk;

  ram4k_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
    .ram_out(ram_out)
  );

  // RAM model: registered read, old data on read-during-write.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
    ram_out <= mem[ram_address];
  end

  typedef struct {
    logic        a_req; logic a_we; logic [11:0] a_addr; logic [15:0] a_wd;
    logic        b_req; logic b_we; logic [11:0] b_addr; logic [15:0] b_wd;
    logic        ea;    logic eb;
  } vec_t;

  typedef struct {
    bit          src;   // 0 = A, 1 = B
    logic [15:0] data;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  logic [15:0] ref_mem [0:4095];
  bit          exp_ld   [int];
  logic [11:0] exp_ld_a [int];
  logic [15:0] exp_ld_d [int];
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [11:0] aa,
                              input logic [15:0] ad, input logic br, input logic bw,
                              input logic [11:0] ba, input logic [15:0] bd,
                              input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Record what an accepted command must produce: a RAM write next cycle, or a response at +2.
  task automatic record(input bit src, input logic we, input logic [11:0] addr,
                        input logic [15:0] wd);
    rsp_t e;
    if (we) begin
      ref_mem[addr]   = wd;
      exp_ld[cyc+1]   = 1'b1;
      exp_ld_a[cyc+1] = addr;
      exp_ld_d[cyc+1] = wd;
    end else begin
      e.src  = src;
      e.data = ref_mem[addr];
      e.due  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // Compare RAM drive and read responses of the current cycle against expectations.
  task automatic mon();
    rsp_t e;
    bit   ld;
    ld = exp_ld.exists(cyc) ? 1'b1 : 1'b0;
    chk("ram_load", 32'(ram_load), 32'(ld));
    if (ld) begin
      chk("ram_address", 32'(ram_address), 32'(exp_ld_a[cyc]));
      chk("ram_in", 32'(ram_in), 32'(exp_ld_d[cyc]));
    end
    if (a_rvalid || b_rvalid) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'({a_rvalid, b_rvalid}), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_src", 32'({a_rvalid, b_rvalid}), e.src ? 32'(1) : 32'(2));
        chk("rsp_data", 32'(b_rvalid ? b_rdata : a_rdata), 32'(e.data));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("rvalid_missing", 32'({a_rvalid, b_rvalid}), e.src ? 32'(1) : 32'(2));
    end
  endtask

  // One clock cycle: drive, check grants and outputs mid-cycle, advance past the next edge.
  task automatic step(input vec_t v, input bit push);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wd;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wd;
    @(negedge clk);
    chk("a_gnt", 32'(a_gnt), 32'(v.ea));
    chk("b_gnt", 32'(b_gnt), 32'(v.eb));
    if (push && v.ea) record(1'b0, v.a_we, v.a_addr, v.a_wd);
    if (push && v.eb) record(1'b1, v.b_we, v.b_addr, v.b_wd);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t idle;
    idle = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    @(posedge clk);
    #1;

    // While reset is held, grants are forced low and the outputs show their reset values.
    step(mk(1'b1, 1'b0, 12'h005, 16'h0, 1'b1, 1'b0, 12'h006, 16'h0, 1'b0, 1'b0), 1'b0);
    chk("rst_ram_address", 32'(ram_address), 32'(0));
    chk("rst_ram_in", 32'(ram_in), 32'(0));
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'(0));
    step(mk(1'b1, 1'b1, 12'h005, 16'h9, 1'b1, 1'b0, 12'h006, 16'h0, 1'b0, 1'b0), 1'b0);
    reset = 1'b0;

    // Stimulus table.
    tbl.push_back(mk(1'b1, 1'b1, 12'h005, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(idle);
    tbl.push_back(mk(1'b1, 1'b0, 12'h005, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 12'h010, 16'hAAAA, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b1, 12'h020, 16'hBBBB, 1'b0, 1'b1));
`ifdef RAM4K_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b0, 12'h020, 16'h0,
                       (i % 2 == 0), (i % 2 == 1)));
`else
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b0, 12'h020, 16'h0, 1'b1, 1'b0));
`endif
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b1, 12'hFFF, 16'h5555, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 12'hFFF, 16'h0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 12'h000, 16'h0001, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 12'hFFF, 16'hFFFF, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 12'hFFF, 16'h0, 1'b0, 1'b1));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(idle);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

    // A pulses a_req and drops it before the edge while B is asking; only B is accepted.
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
    #2;
    step(mk(1'b0, 1'b0, 12'h005, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b1), 1'b1);

`ifdef RAM4K_ARB_ROUND_ROBIN_EN
    // A is granted, then loses a tie to B, then withdraws; it gets exactly one response.
    step(mk(1'b1, 1'b0, 12'h005, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0), 1'b1);
    step(mk(1'b1, 1'b0, 12'h020, 16'h0, 1'b1, 1'b0, 12'h005, 16'h0, 1'b0, 1'b1), 1'b1);
    step(idle, 1'b1);
`endif

    // A read is accepted, then a B write; reset is asserted while both are in flight.
    // Nothing may come back, and the write must not land.
    step(mk(1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0), 1'b0);
    step(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b1, 12'h020, 16'h7777, 1'b0, 1'b1), 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ram_load", 32'(ram_load), 32'(0));
    chk("rst_mid_rvalid", 32'({a_rvalid, b_rvalid}), 32'(0));
    step(idle, 1'b0);
    chk("rst_mid_ram_address", 32'(ram_address), 32'(0));
    step(idle, 1'b0);
    reset = 1'b0;
    // The first tie after reset goes to A; 0x020 must still hold 0xBBBB.
    step(mk(1'b1, 1'b0, 12'h020, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0, 1'b1, 1'b0), 1'b1);
    step(mk(1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0, 1'b0, 1'b1), 1'b1);
    for (int i = 0; i < 4; i++) step(idle, 1'b1);

    chk("responses_outstanding", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
